// File: rtl/lc3b_fetch_stage.sv
// LC-3b instruction-fetch stage.
// Keeps the fetch PC, runs the instruction-memory read handshake and buffers
// one fetched instruction for decode. A one-entry pending buffer absorbs a
// response that lands while decode is stalled. Redirects that arrive during
// an outstanding request are deferred until that request completes, so the
// memory never sees its address or read strobe change mid-request.
module lc3b_fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] imem_address,
   output logic        imem_read,
   input  logic        imem_resp,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic [15:0] if_pc_plus2,
   output logic [3:0]  if_opcode,
   output logic [2:0]  if_bits4_5_11
);

   // FETCH:   request outstanding at pc_reg
   // PEND:    response parked in the pending buffer, no request issued
   // DISCARD: old request still outstanding, its data will be thrown away
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      PEND    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state_reg;
   logic [15:0] pc_reg;
   logic [15:0] target_reg;
   logic [15:0] pend_instr_reg;
   logic [15:0] pend_pc_reg;
   logic        slot_valid_reg;
   logic [15:0] slot_instr_reg;
   logic [15:0] slot_pc_reg;

   logic        slot_consumed;
   logic        slot_free;
   logic [15:0] redirect_target;
   logic [15:0] pc_plus2;

   // Handoff to decode: the slot empties whenever it is valid and not stalled.
   assign slot_consumed   = slot_valid_reg && !stall;
   assign slot_free       = !slot_valid_reg || !stall;
   // Instructions are halfword aligned, so the low target bit is dropped.
   assign redirect_target = redirect_pc & 16'hFFFE;
   assign pc_plus2        = pc_reg + 16'd2;

   // Fetch state machine, PC, pending buffer and output slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= FETCH;
         pc_reg         <= RESET_PC;
         target_reg     <= 16'h0000;
         pend_instr_reg <= 16'h0000;
         pend_pc_reg    <= 16'h0000;
         slot_valid_reg <= 1'b0;
         slot_instr_reg <= 16'h0000;
         slot_pc_reg    <= 16'h0000;
      end else begin
         // A consumed slot empties unless something below refills it.
         if (slot_consumed) begin
            slot_valid_reg <= 1'b0;
         end
         case (state_reg)
            FETCH: begin
               if (redirect) begin
                  slot_valid_reg <= 1'b0;
                  if (imem_resp) begin
                     // Request just completed: drop its data, restart at target.
                     pc_reg <= redirect_target;
                  end else begin
                     // Request still outstanding: remember target, wait it out.
                     target_reg <= redirect_target;
                     state_reg  <= DISCARD;
                  end
               end else if (imem_resp) begin
                  pc_reg <= pc_plus2;
                  if (slot_free) begin
                     slot_valid_reg <= 1'b1;
                     slot_instr_reg <= imem_rdata;
                     slot_pc_reg    <= pc_reg;
                  end else begin
                     pend_instr_reg <= imem_rdata;
                     pend_pc_reg    <= pc_reg;
                     state_reg      <= PEND;
                  end
               end
            end
            PEND: begin
               if (redirect) begin
                  // Pending word is abandoned simply by leaving PEND.
                  slot_valid_reg <= 1'b0;
                  pc_reg         <= redirect_target;
                  state_reg      <= FETCH;
               end else if (slot_free) begin
                  slot_valid_reg <= 1'b1;
                  slot_instr_reg <= pend_instr_reg;
                  slot_pc_reg    <= pend_pc_reg;
                  state_reg      <= FETCH;
               end
            end
            DISCARD: begin
               slot_valid_reg <= 1'b0;
               if (redirect) begin
                  target_reg <= redirect_target;
                  if (imem_resp) begin
                     pc_reg    <= redirect_target;
                     state_reg <= FETCH;
                  end
               end else if (imem_resp) begin
                  pc_reg    <= target_reg;
                  state_reg <= FETCH;
               end
            end
            default: begin
               state_reg <= FETCH;
            end
         endcase
      end
   end

   // Memory request: the address register only moves when a request completes
   // or no request is issued, which keeps an outstanding request stable.
   assign imem_read    = !reset && (state_reg != PEND);
   assign imem_address = pc_reg;

   // Slot outputs plus the fields the control ROM indexes with.
   assign if_valid      = slot_valid_reg;
   assign if_instr      = slot_instr_reg;
   assign if_pc         = slot_pc_reg;
   assign if_pc_plus2   = slot_pc_reg + 16'd2;
   assign if_opcode     = slot_instr_reg[15:12];
   assign if_bits4_5_11 = {slot_instr_reg[11], slot_instr_reg[5], slot_instr_reg[4]};

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Testbench for lc3b_fetch_stage: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the fetch stage.
// A second instance with RESET_PC = 16'hFFFE covers PC wraparound.
module tb_lc3b_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] imem_address;
   logic        imem_read;
   logic        imem_resp = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [15:0] if_pc_plus2;
   logic [3:0]  if_opcode;
   logic [2:0]  if_bits4_5_11;

   logic        w_reset = 1'b1;
   logic [15:0] w_address;
   logic        w_read;
   logic        w_resp = 1'b0;
   logic [15:0] w_rdata = 16'h0000;
   logic        w_valid;
   logic [15:0] w_instr;
   logic [15:0] w_pc;
   logic [15:0] w_pc_plus2;
   logic [3:0]  w_opcode;
   logic [2:0]  w_bits;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lc3b_fetch_stage #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset),
      .imem_address(imem_address), .imem_read(imem_read),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_pc_plus2(if_pc_plus2), .if_opcode(if_opcode),
      .if_bits4_5_11(if_bits4_5_11)
   );

   lc3b_fetch_stage #(.RESET_PC(16'hFFFE)) dut_wrap (
      .clk(clk), .reset(w_reset),
      .imem_address(w_address), .imem_read(w_read),
      .imem_resp(w_resp), .imem_rdata(w_rdata),
      .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
      .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc),
      .if_pc_plus2(w_pc_plus2), .if_opcode(w_opcode),
      .if_bits4_5_11(w_bits)
   );

   // Single comparison point: counts every check, reports mismatches.
   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Memory contents: a few known instructions at the bottom, a hash elsewhere.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h1261;
         16'h0002: return 16'h5020;
         16'h0004: return 16'h6042;
         default:  return {a[6:0], a[15:7]} ^ 16'h3C5A;
      endcase
   endfunction

   // Reference model: slot and pending buffer as a queue of up to two entries.
   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   entry_t      m_q[$];
   logic [15:0] m_pc = 16'h0000;
   logic [15:0] m_target = 16'h0000;
   bit          m_discard = 1'b0;
   bit          m_known = 1'b0;

   function automatic bit model_read(input logic rst);
      return !rst && (m_discard || m_q.size() < 2);
   endfunction

   task automatic model_step(input logic rst, input logic rsp, input logic [15:0] rdata,
                             input logic stl, input logic rdr, input logic [15:0] rpc);
      bit          req;
      bit          full;
      logic [15:0] tgt;
      if (rst) begin
         m_q.delete();
         m_pc      = 16'h0000;
         m_discard = 1'b0;
         m_known   = 1'b1;
         return;
      end
      req  = m_discard || m_q.size() < 2;
      full = !m_discard && m_q.size() == 2;
      tgt  = rpc & 16'hFFFE;
      if (rdr) begin
         m_q.delete();
         if (m_discard) begin
            m_target = tgt;
            if (rsp) begin
               m_pc      = tgt;
               m_discard = 1'b0;
            end
         end else if (full || rsp) begin
            m_pc = tgt;
         end else begin
            m_discard = 1'b1;
            m_target  = tgt;
         end
      end else begin
         if (m_q.size() > 0 && !stl) void'(m_q.pop_front());
         if (rsp && req) begin
            if (m_discard) begin
               m_pc      = m_target;
               m_discard = 1'b0;
            end else begin
               m_q.push_back('{instr: rdata, pc: m_pc});
               m_pc = m_pc + 16'd2;
            end
         end
      end
   endtask

   task automatic compare_model(input logic rst);
      logic        exp_read;
      logic [15:0] ins;
      exp_read = model_read(rst);
      check_eq("imem_read", {15'd0, imem_read}, {15'd0, exp_read});
      if (exp_read) check_eq("imem_address", imem_address, m_pc);
      if (m_known) begin
         check_eq("if_valid", {15'd0, if_valid}, (m_q.size() > 0) ? 16'd1 : 16'd0);
         if (m_q.size() > 0) begin
            ins = m_q[0].instr;
            check_eq("if_instr", if_instr, ins);
            check_eq("if_pc", if_pc, m_q[0].pc);
            check_eq("if_pc_plus2", if_pc_plus2, m_q[0].pc + 16'd2);
            check_eq("if_opcode", {12'd0, if_opcode}, ins >> 12);
            check_eq("if_bits4_5_11", {13'd0, if_bits4_5_11},
                     ((ins >> 11) & 16'd1) * 16'd4 + ((ins >> 4) & 16'd3));
         end
      end
   endtask

   // One clock: apply inputs, check outputs mid-cycle, let memory answer if
   // asked, then advance the model on the rising edge.
   task automatic cycle(input logic rst, input logic rsp_en, input logic stl,
                        input logic rdr, input logic [15:0] rpc);
      @(negedge clk);
      reset       = rst;
      stall       = stl;
      redirect    = rdr;
      redirect_pc = rpc;
      imem_resp   = 1'b0;
      #1;
      compare_model(rst);
      imem_resp  = rsp_en && imem_read;
      imem_rdata = mem_word(imem_address);
      @(posedge clk);
      model_step(rst, imem_resp, imem_rdata, stl, rdr, rpc);
   endtask

   initial begin
      int lat;
      // Reset and first fetch with three-cycle memory latency.
      cycle(1, 0, 0, 0, 16'h0);
      cycle(1, 0, 0, 0, 16'h0);
      cycle(0, 0, 0, 0, 16'h0);
      cycle(0, 0, 0, 0, 16'h0);
      cycle(0, 0, 0, 0, 16'h0);
      cycle(0, 1, 0, 0, 16'h0);
      #1;
      check_eq("first_valid", {15'd0, if_valid}, 16'd1);
      check_eq("first_opcode", {12'd0, if_opcode}, 16'h0001);
      check_eq("first_pc", if_pc, 16'h0000);
      check_eq("first_pc_plus2", if_pc_plus2, 16'h0002);
      check_eq("next_addr", imem_address, 16'h0002);

      // Back-to-back same-cycle responses.
      cycle(0, 1, 0, 0, 16'h0);
      #1;
      check_eq("b2b_pc1", if_pc, 16'h0002);
      check_eq("b2b_bits", {13'd0, if_bits4_5_11}, 16'b010);
      cycle(0, 1, 0, 0, 16'h0);
      #1;
      check_eq("b2b_pc2", if_pc, 16'h0004);

      // Stall into PEND, then release.
      cycle(1, 0, 0, 0, 16'h0);
      cycle(0, 1, 0, 0, 16'h0);
      cycle(0, 1, 1, 0, 16'h0);
      #1;
      check_eq("pend_read", {15'd0, imem_read}, 16'd0);
      check_eq("pend_slot_pc", if_pc, 16'h0000);
      cycle(0, 0, 1, 0, 16'h0);
      #1;
      check_eq("pend_hold_pc", if_pc, 16'h0000);
      cycle(0, 0, 0, 0, 16'h0);
      #1;
      check_eq("pend_release_pc", if_pc, 16'h0002);
      check_eq("pend_release_read", {15'd0, imem_read}, 16'd1);
      check_eq("pend_release_addr", imem_address, 16'h0004);

      // Redirect while the 0x0006 request is outstanding.
      cycle(0, 1, 0, 0, 16'h0);
      cycle(0, 0, 0, 1, 16'h0100);
      #1;
      check_eq("disc_addr_held", imem_address, 16'h0006);
      check_eq("disc_valid", {15'd0, if_valid}, 16'd0);
      cycle(0, 1, 0, 0, 16'h0);
      #1;
      check_eq("disc_drop_valid", {15'd0, if_valid}, 16'd0);
      check_eq("disc_new_addr", imem_address, 16'h0100);

      // Redirect, response and stall in the same cycle.
      cycle(0, 1, 0, 0, 16'h0);
      cycle(0, 1, 1, 1, 16'h0201);
      #1;
      check_eq("rrs_valid", {15'd0, if_valid}, 16'd0);
      check_eq("rrs_addr", imem_address, 16'h0200);

      // Randomized traffic with variable memory latency.
      lat = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 250) == 0, lat == 0, ($urandom % 3) == 0,
               ($urandom % 12) == 0, 16'($urandom));
         if (imem_resp) lat = $urandom_range(0, 3);
         else if (lat > 0) lat--;
      end

      // Wraparound on the RESET_PC = 16'hFFFE instance.
      @(negedge clk);
      w_reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      w_reset = 1'b0;
      #1;
      check_eq("wrap_read", {15'd0, w_read}, 16'd1);
      check_eq("wrap_addr0", w_address, 16'hFFFE);
      w_resp  = 1'b1;
      w_rdata = 16'h1234;
      @(negedge clk);
      w_resp = 1'b0;
      check_eq("wrap_valid", {15'd0, w_valid}, 16'd1);
      check_eq("wrap_pc", w_pc, 16'hFFFE);
      check_eq("wrap_pc_plus2", w_pc_plus2, 16'h0000);
      check_eq("wrap_next_addr", w_address, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
